spi_flash_id_responder: RTL and testbench

- SPI mode-0 slave that emulates the identification and status front end of a serial NOR flash.
- Answers RDID (0x9F) with a 3-byte JEDEC ID and RDSR (0x05) with a status byte.
- Serves as the synthesizable far end for bring-up and loopback of the on-chip SPI flash ID reader, and as a bench responder.
- SCK, CS_n and MOSI are oversampled in the sys_clk domain; no logic runs on SCK.

---
 rtl/spi_flash_id_responder.sv | 181 ++++++++++++++++++
 tb/tb_spi_flash_id_responder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_id_responder.sv
// SPI mode-0 slave emulating the RDID/RDSR front end of a serial NOR flash.
// SCK, CS_n and MOSI are oversampled in the sys_clk domain.
module spi_flash_id_responder #(
    parameter logic [23:0] JEDEC_ID = 24'h202015,
    parameter logic [7:0]  STATUS   = 8'h00
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] cmd_code,
    output logic       cmd_valid,
    output logic       id_sent,
    output logic [7:0] rdid_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_RESP_ID,
        S_RESP_SR,
        S_IGNORE
    } state_t;

    state_t state, state_nxt;

    logic sck_s1, sck_s2, sck_d;
    logic cs_s1, cs_s2, cs_d;
    logic mosi_s1, mosi_s2;

    logic       sck_rise, sck_fall, cs_fall, cs_high;
    logic [2:0] bit_cnt;
    logic [1:0] byte_idx, byte_nxt;
    logic [7:0] rx_sh, tx_sh, cmd_byte, id_byte;
    logic       miso_r, started, cmd_done;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_d   <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_d    <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sck_s1  <= spi_sck;
            sck_s2  <= sck_s1;
            sck_d   <= sck_s2;
            cs_s1   <= spi_cs_n;
            cs_s2   <= cs_s1;
            cs_d    <= cs_s2;
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    assign sck_rise = sck_s2 & ~sck_d;
    assign sck_fall = ~sck_s2 & sck_d;
    assign cs_fall  = ~cs_s2 & cs_d;
    assign cs_high  = cs_s2;

    assign cmd_byte = {rx_sh[6:0], mosi_s2};
    assign cmd_done = (state == S_CMD) && sck_rise && (bit_cnt == 3'd7);
    assign byte_nxt = (byte_idx == 2'd2) ? 2'd0 : byte_idx + 2'd1;

    always_comb begin
        case (byte_nxt)
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = JEDEC_ID[23:16];
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cs_high) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (cs_fall) state_nxt = S_CMD;
                S_CMD: begin
                    if (cmd_done) begin
                        if (cmd_byte == 8'h9F)      state_nxt = S_RESP_ID;
                        else if (cmd_byte == 8'h05) state_nxt = S_RESP_SR;
                        else                        state_nxt = S_IGNORE;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        spi_miso_oe = 1'b0;
        spi_miso    = 1'b0;
        if (state == S_RESP_ID || state == S_RESP_SR) begin
            spi_miso_oe = 1'b1;
            spi_miso    = miso_r;
        end
    end

    // tx_sh holds the byte being shifted; byte_idx names that byte
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bit_cnt    <= 3'd0;
            byte_idx   <= 2'd0;
            rx_sh      <= 8'h00;
            tx_sh      <= 8'h00;
            miso_r     <= 1'b0;
            started    <= 1'b0;
            cmd_code   <= 8'h00;
            cmd_valid  <= 1'b0;
            id_sent    <= 1'b0;
            rdid_count <= 8'h00;
        end else begin
            cmd_valid <= 1'b0;
            id_sent   <= 1'b0;
            if (cs_high) begin
                bit_cnt <= 3'd0;
                miso_r  <= 1'b0;
                started <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cs_fall) begin
                            bit_cnt <= 3'd0;
                            rx_sh   <= 8'h00;
                        end
                    end
                    S_CMD: begin
                        if (sck_rise) begin
                            rx_sh   <= cmd_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        if (cmd_done) begin
                            cmd_code  <= cmd_byte;
                            cmd_valid <= 1'b1;
                            byte_idx  <= 2'd0;
                            started   <= 1'b0;
                            miso_r    <= 1'b0;
                            tx_sh     <= (cmd_byte == 8'h05) ? STATUS
                                                             : JEDEC_ID[23:16];
                        end
                    end
                    S_RESP_ID, S_RESP_SR: begin
                        if (sck_fall) begin
                            miso_r  <= tx_sh[7];
                            started <= 1'b1;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                byte_idx <= byte_nxt;
                                tx_sh    <= (state == S_RESP_SR) ? STATUS
                                                                 : id_byte;
                            end else begin
                                tx_sh <= {tx_sh[6:0], 1'b0};
                            end
                        end else if (sck_rise && state == S_RESP_ID && started
                                     && bit_cnt == 3'd0 && byte_idx == 2'd0) begin
                            // master is sampling bit 0 of byte2
                            id_sent <= 1'b1;
                            if (rdid_count != 8'hFF)
                                rdid_count <= rdid_count + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_id_responder.sv
// Directed bench for spi_flash_id_responder acting as a mode-0 SPI master.
// Each task drives one scenario and checks inline.
module tb_spi_flash_id_responder;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       spi_sck = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] cmd_code;
    logic       cmd_valid;
    logic       id_sent;
    logic [7:0] rdid_count;

    spi_flash_id_responder #(
        .JEDEC_ID(24'h202015),
        .STATUS  (8'hA5)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .spi_sck    (spi_sck),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .cmd_code   (cmd_code),
        .cmd_valid  (cmd_valid),
        .id_sent    (id_sent),
        .rdid_count (rdid_count)
    );

    always #5 sys_clk = ~sys_clk;

    int half = 5;
    int tests = 0;
    int fails = 0;

    int cv_cnt = 0;
    int ids_cnt = 0;
    int oe_cnt = 0;
    int multi = 0;
    logic cv_q = 1'b0;
    logic ids_q = 1'b0;

    always @(negedge sys_clk) begin
        if (cmd_valid) cv_cnt++;
        if (id_sent) ids_cnt++;
        if (spi_miso_oe) oe_cnt++;
        if ((cmd_valid && cv_q) || (id_sent && ids_q)) multi++;
        cv_q = cmd_valid;
        ids_q = id_sent;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic sck_bit(input logic b, output logic r);
        spi_mosi = b;
        wait_n(half);
        r = spi_miso;
        spi_sck = 1'b1;
        wait_n(half);
        spi_sck = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] t, output logic [7:0] r);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            sck_bit(t[i], b);
            r[i] = b;
        end
    endtask

    task automatic frame(input logic [7:0] cmd, input int nresp,
                         output logic [31:0] rx);
        logic [7:0] r;
        rx = 32'h0;
        spi_cs_n = 1'b0;
        wait_n(half);
        xfer(cmd, r);
        for (int k = 0; k < nresp; k++) begin
            xfer(8'h00, r);
            rx = {rx[23:0], r};
        end
        wait_n(half);
        spi_cs_n = 1'b1;
        wait_n(8);
    endtask

    task automatic test_reset();
        logic [7:0]  r;
        logic        b;
        logic [31:0] rx;
        wait_n(4);
        tests++;
        if (spi_miso !== 1'b0) begin
            fails++; $display("FAIL rst_miso: got %b expected 0", spi_miso);
        end
        tests++;
        if (spi_miso_oe !== 1'b0) begin
            fails++; $display("FAIL rst_oe: got %b expected 0", spi_miso_oe);
        end
        tests++;
        if (cmd_code !== 8'h00) begin
            fails++; $display("FAIL rst_cmd_code: got %h expected 00", cmd_code);
        end
        tests++;
        if (cmd_valid !== 1'b0 || id_sent !== 1'b0) begin
            fails++;
            $display("FAIL rst_pulses: got cv=%b ids=%b expected 0 0",
                     cmd_valid, id_sent);
        end
        tests++;
        if (rdid_count !== 8'h00) begin
            fails++; $display("FAIL rst_count: got %h expected 00", rdid_count);
        end
        sys_rst_n = 1'b1;
        wait_n(4);
        spi_cs_n = 1'b0;
        wait_n(half);
        xfer(8'h9F, r);
        xfer(8'h00, r);
        sck_bit(1'b0, b);
        sck_bit(1'b0, b);
        wait_n(2);
        tests++;
        if (spi_miso_oe !== 1'b1 || cmd_code !== 8'h9F) begin
            fails++;
            $display("FAIL mid_rdid: got oe=%b cmd=%h expected 1 9f",
                     spi_miso_oe, cmd_code);
        end
        sys_rst_n = 1'b0;
        #1;
        tests++;
        if ({spi_miso, spi_miso_oe, cmd_code, cmd_valid, id_sent, rdid_count}
            !== 20'h0) begin
            fails++;
            $display("FAIL mid_reset: got miso=%b oe=%b cmd=%h cv=%b ids=%b cnt=%h expected all 0",
                     spi_miso, spi_miso_oe, cmd_code, cmd_valid, id_sent, rdid_count);
        end
        spi_cs_n = 1'b1;
        wait_n(4);
        sys_rst_n = 1'b1;
        wait_n(4);
        frame(8'h9F, 3, rx);
        tests++;
        if (rx[23:0] !== 24'h202015 || rdid_count !== 8'd1) begin
            fails++;
            $display("FAIL post_reset_rdid: got id=%h cnt=%0d expected 202015 1",
                     rx[23:0], rdid_count);
        end
    endtask

    task automatic test_rdid();
        logic [31:0] rx;
        int cv0, ids0;
        cv0 = cv_cnt;
        ids0 = ids_cnt;
        frame(8'h9F, 3, rx);
        tests++;
        if (rx[23:0] !== 24'h202015) begin
            fails++; $display("FAIL rdid_id: got %h expected 202015", rx[23:0]);
        end
        tests++;
        if (cmd_code !== 8'h9F || cv_cnt - cv0 != 1) begin
            fails++;
            $display("FAIL rdid_cmd: got cmd=%h cv=%0d expected 9f 1",
                     cmd_code, cv_cnt - cv0);
        end
        tests++;
        if (ids_cnt - ids0 != 1 || rdid_count !== 8'd2) begin
            fails++;
            $display("FAIL rdid_ids: got ids=%0d cnt=%0d expected 1 2",
                     ids_cnt - ids0, rdid_count);
        end
    endtask

    task automatic test_rdid_wrap();
        logic [31:0] rx;
        int ids0;
        ids0 = ids_cnt;
        frame(8'h9F, 4, rx);
        tests++;
        if (rx !== 32'h20201520) begin
            fails++; $display("FAIL rdid_wrap: got %h expected 20201520", rx);
        end
        tests++;
        if (ids_cnt - ids0 != 1 || rdid_count !== 8'd3) begin
            fails++;
            $display("FAIL wrap_ids: got ids=%0d cnt=%0d expected 1 3",
                     ids_cnt - ids0, rdid_count);
        end
    endtask

    task automatic test_rdsr();
        logic [31:0] rx;
        int ids0;
        ids0 = ids_cnt;
        frame(8'h05, 2, rx);
        tests++;
        if (rx[15:0] !== 16'hA5A5) begin
            fails++; $display("FAIL rdsr_data: got %h expected a5a5", rx[15:0]);
        end
        tests++;
        if (cmd_code !== 8'h05 || ids_cnt != ids0) begin
            fails++;
            $display("FAIL rdsr_cmd: got cmd=%h ids=%0d expected 05 0",
                     cmd_code, ids_cnt - ids0);
        end
    endtask

    task automatic test_unknown();
        logic [31:0] rx;
        int cv0, oe0;
        cv0 = cv_cnt;
        oe0 = oe_cnt;
        frame(8'h03, 2, rx);
        tests++;
        if (cmd_code !== 8'h03 || cv_cnt - cv0 != 1) begin
            fails++;
            $display("FAIL unk_cmd: got cmd=%h cv=%0d expected 03 1",
                     cmd_code, cv_cnt - cv0);
        end
        tests++;
        if (oe_cnt != oe0 || rx[15:0] !== 16'h0000) begin
            fails++;
            $display("FAIL unk_oe: got oe_cycles=%0d data=%h expected 0 0000",
                     oe_cnt - oe0, rx[15:0]);
        end
        tests++;
        if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) begin
            fails++;
            $display("FAIL unk_idle: got oe=%b miso=%b expected 0 0",
                     spi_miso_oe, spi_miso);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rx;
        logic [7:0]  t;
        logic        b;
        int cv0;
        t = 8'h9F;
        cv0 = cv_cnt;
        spi_cs_n = 1'b0;
        wait_n(half);
        for (int i = 7; i >= 4; i--) sck_bit(t[i], b);
        wait_n(half);
        spi_cs_n = 1'b1;
        wait_n(8);
        tests++;
        if (cv_cnt != cv0) begin
            fails++; $display("FAIL abort_cv: got %0d expected 0", cv_cnt - cv0);
        end
        frame(8'h9F, 3, rx);
        tests++;
        if (rx[23:0] !== 24'h202015 || cv_cnt - cv0 != 1) begin
            fails++;
            $display("FAIL abort_rdid: got id=%h cv=%0d expected 202015 1",
                     rx[23:0], cv_cnt - cv0);
        end
    endtask

    task automatic test_saturate();
        logic [31:0] rx;
        half = 4;
        for (int n = 0; n < 256; n++) frame(8'h9F, 3, rx);
        tests++;
        if (rdid_count !== 8'hFF) begin
            fails++; $display("FAIL saturate: got %h expected ff", rdid_count);
        end
        tests++;
        if (rx[23:0] !== 24'h202015) begin
            fails++; $display("FAIL fast_rdid: got %h expected 202015", rx[23:0]);
        end
        tests++;
        if (multi != 0) begin
            fails++; $display("FAIL pulse_width: got %0d long pulses expected 0", multi);
        end
    endtask

    initial begin
        test_reset();
        test_rdid();
        test_rdid_wrap();
        test_rdsr();
        test_unknown();
        test_abort();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
